// File: rtl/read_arbiter.sv
// Two-master (IFU/LSU) to one-slave read arbiter, one outstanding transaction.
// Define ARB_ROUND_ROBIN_EN for alternating tie-break; otherwise LSU wins ties.
module read_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  // fetch master
  input  logic                  ifu_arvalid_i,
  input  logic [ADDR_WIDTH-1:0] ifu_araddr_i,
  output logic                  ifu_arready_o,
  output logic                  ifu_rvalid_o,
  // load master
  input  logic                  lsu_arvalid_i,
  input  logic [ADDR_WIDTH-1:0] lsu_araddr_i,
  output logic                  lsu_arready_o,
  output logic                  lsu_rvalid_o,
  // shared read return
  output logic [31:0]           rdata_o,
  output logic [1:0]            rresp_o,
  // slave side
  output logic                  arvalid_o,
  output logic [ADDR_WIDTH-1:0] araddr_o,
  input  logic                  arready_i,
  input  logic                  rvalid_i,
  input  logic [31:0]           rdata_i,
  input  logic [1:0]            rresp_i,
  output logic                  rready_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA
  } state_t;

  typedef enum logic {
    M_IFU,
    M_LSU
  } master_t;

  state_t                r_state;
  master_t               r_owner;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_arvalid;
  logic                  r_rready;

  logic w_in_idle;
  logic w_accept;
  logic w_grant_lsu;
  logic w_rdone;

`ifdef ARB_ROUND_ROBIN_EN
  master_t r_last;

  // On a tie the master that did not win the previous grant goes first.
  always_comb begin
    w_grant_lsu = lsu_arvalid_i & (~ifu_arvalid_i | (r_last == M_IFU));
  end
`else
  always_comb begin
    w_grant_lsu = lsu_arvalid_i;
  end
`endif

  always_comb begin
    w_in_idle = (r_state == S_IDLE) & ~reset;
    w_accept  = w_in_idle & (ifu_arvalid_i | lsu_arvalid_i);
    w_rdone   = (r_state == S_DATA) & rvalid_i & ~reset;
  end

  // Outputs are masked by reset so they read zero in the reset cycle itself.
  always_comb begin
    ifu_arready_o = w_in_idle & ifu_arvalid_i & ~w_grant_lsu;
    lsu_arready_o = w_in_idle & w_grant_lsu;
    ifu_rvalid_o  = w_rdone & (r_owner == M_IFU);
    lsu_rvalid_o  = w_rdone & (r_owner == M_LSU);
    rdata_o       = w_rdone ? rdata_i : '0;
    rresp_o       = w_rdone ? rresp_i : '0;
    arvalid_o     = r_arvalid & ~reset;
    araddr_o      = (r_arvalid & ~reset) ? r_addr : '0;
    rready_o      = r_rready & ~reset;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_owner   <= M_IFU;
      r_addr    <= '0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last    <= M_LSU;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state   <= S_ADDR;
            r_owner   <= w_grant_lsu ? M_LSU : M_IFU;
            r_addr    <= w_grant_lsu ? lsu_araddr_i : ifu_araddr_i;
            r_arvalid <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            r_last    <= w_grant_lsu ? M_LSU : M_IFU;
`endif
          end
        end
        S_ADDR: begin
          if (arready_i) begin
            r_state   <= S_DATA;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
          end
        end
        S_DATA: begin
          if (rvalid_i) begin
            r_state  <= S_IDLE;
            r_rready <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_arvalid <= 1'b0;
          r_rready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_read_arbiter.sv
// Self-checking bench for read_arbiter: cycle model plus a grant scoreboard.
// Tie-order expectations follow ARB_ROUND_ROBIN_EN when defined.
module tb_read_arbiter;

  localparam int AW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          ifu_arvalid_i, lsu_arvalid_i;
  logic [AW-1:0] ifu_araddr_i, lsu_araddr_i;
  logic          ifu_arready_o, lsu_arready_o, ifu_rvalid_o, lsu_rvalid_o;
  logic [31:0]   rdata_o;
  logic [1:0]    rresp_o;
  logic          arvalid_o;
  logic [AW-1:0] araddr_o;
  logic          arready_i, rvalid_i, rready_o;
  logic [31:0]   rdata_i;
  logic [1:0]    rresp_i;

  always #5 clock = ~clock;

  read_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clock         (clock),
    .reset         (reset),
    .ifu_arvalid_i (ifu_arvalid_i),
    .ifu_araddr_i  (ifu_araddr_i),
    .ifu_arready_o (ifu_arready_o),
    .ifu_rvalid_o  (ifu_rvalid_o),
    .lsu_arvalid_i (lsu_arvalid_i),
    .lsu_araddr_i  (lsu_araddr_i),
    .lsu_arready_o (lsu_arready_o),
    .lsu_rvalid_o  (lsu_rvalid_o),
    .rdata_o       (rdata_o),
    .rresp_o       (rresp_o),
    .arvalid_o     (arvalid_o),
    .araddr_o      (araddr_o),
    .arready_i     (arready_i),
    .rvalid_i      (rvalid_i),
    .rdata_i       (rdata_i),
    .rresp_i       (rresp_i),
    .rready_o      (rready_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] slave_data(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'hDEAD_BEEF);
  endfunction

  typedef enum logic [1:0] {M_IDLE, M_ADDR, M_DATA} mstate_t;
  typedef struct packed {
    logic        owner;  // 1 = LSU
    logic [31:0] addr;
  } txn_t;

  mstate_t     m_state = M_IDLE;
  logic        m_owner = 1'b0;
  logic        m_last  = 1'b1;
  logic [31:0] m_addr  = '0;
  int          ar_cnt  = 0;
  int          r_cnt   = 0;
  int          ar_lat  = 0;
  int          r_lat   = 0;
  bit          spur    = 1'b0;
  bit          rst_drv = 1'b1;

  logic [31:0] ifu_q[$];
  logic [31:0] lsu_q[$];
  txn_t        sb[$];
  bit          order_q[$];

  // One clock cycle: drive at negedge, check at +1, advance the model.
  task automatic step();
    bit          win, grant;
    bit          e_ifu_ar, e_lsu_ar, e_arv, e_rr, e_ifu_rv, e_lsu_rv;
    logic [31:0] e_addr, e_rdata;
    logic [1:0]  e_rresp;
    txn_t        t;
    @(negedge clock);
    reset         = rst_drv;
    ifu_arvalid_i = (ifu_q.size() > 0);
    ifu_araddr_i  = (ifu_q.size() > 0) ? ifu_q[0] : $urandom;
    lsu_arvalid_i = (lsu_q.size() > 0);
    lsu_araddr_i  = (lsu_q.size() > 0) ? lsu_q[0] : $urandom;
    arready_i     = (m_state == M_ADDR) ? (ar_cnt >= ar_lat) : spur;
    if (m_state == M_DATA) begin
      rvalid_i = (r_cnt >= r_lat);
      rdata_i  = rvalid_i ? slave_data(m_addr) : $urandom;
      rresp_i  = m_addr[5:4];
    end else begin
      rvalid_i = spur;
      rdata_i  = $urandom;
      rresp_i  = 2'($urandom);
    end
    #1;
    win = 1'b0; grant = 1'b0;
    e_ifu_ar = 1'b0; e_lsu_ar = 1'b0; e_arv = 1'b0; e_rr = 1'b0;
    e_ifu_rv = 1'b0; e_lsu_rv = 1'b0; e_addr = '0; e_rdata = '0; e_rresp = '0;
    if (!rst_drv) begin
      case (m_state)
        M_IDLE: if (ifu_arvalid_i || lsu_arvalid_i) begin
          grant = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
          win = lsu_arvalid_i && (!ifu_arvalid_i || (m_last == 1'b0));
`else
          win = lsu_arvalid_i;
`endif
          e_ifu_ar = !win;
          e_lsu_ar = win;
        end
        M_ADDR: begin
          e_arv  = 1'b1;
          e_addr = m_addr;
        end
        M_DATA: begin
          e_rr = 1'b1;
          if (rvalid_i) begin
            e_ifu_rv = !m_owner;
            e_lsu_rv = m_owner;
            e_rdata  = rdata_i;
            e_rresp  = rresp_i;
          end
        end
        default: ;
      endcase
    end
    check("arready", 64'({ifu_arready_o, lsu_arready_o}), 64'({e_ifu_ar, e_lsu_ar}));
    check("rvalid",  64'({ifu_rvalid_o, lsu_rvalid_o}),   64'({e_ifu_rv, e_lsu_rv}));
    check("arvalid", 64'(arvalid_o), 64'(e_arv));
    check("araddr",  64'(araddr_o),  64'(e_addr));
    check("rready",  64'(rready_o),  64'(e_rr));
    check("rdata",   64'(rdata_o),   64'(e_rdata));
    check("rresp",   64'(rresp_o),   64'(e_rresp));
    if (ifu_rvalid_o || lsu_rvalid_o) begin
      order_q.push_back(lsu_rvalid_o);
      check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        t = sb.pop_front();
        check("sb_owner", 64'(lsu_rvalid_o), 64'(t.owner));
        check("sb_rdata", 64'(rdata_o), 64'(slave_data(t.addr)));
        check("sb_rresp", 64'(rresp_o), 64'(t.addr[5:4]));
      end
    end
    if (rst_drv) begin
      m_state = M_IDLE;
      m_last  = 1'b1;
      sb.delete();
    end else begin
      case (m_state)
        M_IDLE: if (grant) begin
          m_owner = win;
          m_last  = win;
          m_addr  = win ? lsu_q.pop_front() : ifu_q.pop_front();
          t.owner = win;
          t.addr  = m_addr;
          sb.push_back(t);
          ar_cnt  = 0;
          m_state = M_ADDR;
        end
        M_ADDR: if (arready_i) begin
          m_state = M_DATA;
          r_cnt   = 0;
        end else ar_cnt++;
        M_DATA: if (rvalid_i) m_state = M_IDLE;
                else r_cnt++;
        default: m_state = M_IDLE;
      endcase
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((m_state != M_IDLE || ifu_q.size() > 0 || lsu_q.size() > 0) && n < budget) begin
      step();
      n++;
    end
    check("drain_budget", 64'(n < budget), 64'd1);
  endtask

  task automatic do_reset();
    rst_drv = 1'b1;
    step();
    rst_drv = 1'b0;
    step();
  endtask

  initial begin
    bit exp_order[4];
    int n;
    reset = 1'b1;
    ifu_arvalid_i = 1'b0; lsu_arvalid_i = 1'b0;
    ifu_araddr_i = '0; lsu_araddr_i = '0;
    arready_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0; rresp_i = '0;
    step();
    do_reset();

    // Minimum-latency fetch
    ifu_q.push_back(32'h8000_0000);
    step();
    step();
    check("lat_arvalid_n1", 64'(arvalid_o), 64'd1);
    check("lat_araddr_n1", 64'(araddr_o), 64'h8000_0000);
    step();
    check("lat_ifu_rvalid_n2", 64'(ifu_rvalid_o), 64'd1);
    check("lat_lsu_rvalid_n2", 64'(lsu_rvalid_o), 64'd0);
    check("lat_rdata_n2", 64'(rdata_o), 64'h0000_0413);
    drain(20);

    // Tie-breaking from reset, two ties in a row
    do_reset();
    order_q.delete();
    ifu_q.push_back(32'h0000_1000);
    lsu_q.push_back(32'h0000_2000);
    drain(50);
    ifu_q.push_back(32'h0000_1110);
    lsu_q.push_back(32'h0000_2120);
    drain(50);
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
`endif
    check("tie_order_len", 64'(order_q.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      if (i < order_q.size()) check($sformatf("tie_order_%0d", i), 64'(order_q[i]), 64'(exp_order[i]));

    // Slave stalls the address phase
    ar_lat = 5; r_lat = 2;
    lsu_q.push_back(32'h3000_0040);
    drain(50);

    // Spurious rvalid_i in IDLE and ADDR
    spur = 1'b1;
    repeat (3) step();
    ar_lat = 3; r_lat = 1;
    ifu_q.push_back(32'h0000_0030);
    drain(50);
    spur = 1'b0;

    // Reset in the middle of a data phase
    ar_lat = 0; r_lat = 20;
    lsu_q.push_back(32'h4000_0000);
    n = 0;
    while (m_state != M_DATA && n < 20) begin
      step();
      n++;
    end
    check("reach_data", 64'(m_state == M_DATA), 64'd1);
    repeat (2) step();
    rst_drv = 1'b1;
    step();
    rst_drv = 1'b0;
    spur = 1'b1;
    repeat (2) step();
    spur = 1'b0;
    r_lat = 0;
    ifu_q.push_back(32'h5000_0010);
    drain(20);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0 && ifu_q.size() < 3) ifu_q.push_back($urandom & 32'hFFFF_FFFC);
      if ($urandom_range(0, 3) == 0 && lsu_q.size() < 3) lsu_q.push_back($urandom & 32'hFFFF_FFFC);
      spur = ($urandom_range(0, 4) == 0);
      if (m_state == M_IDLE) begin
        ar_lat = $urandom_range(0, 3);
        r_lat  = $urandom_range(0, 3);
      end
      step();
    end
    spur = 1'b0;
    drain(200);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
